// File: rtl/philv_fetch_unit.sv
// philv_fetch_unit: PhilosophyV instruction fetch stage (PC, imem requests, instruction queue, redirect flush); optional perf counters under PHILV_FETCH_PERF_EN
module philv_fetch_unit #(
  parameter int N = 32,
  parameter logic [N-1:0] START_ADDR = '0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic         imem_rvalid,
  input  logic [N-1:0] imem_rdata,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_addr,
  output logic         id_valid,
  input  logic         id_ready,
  output logic [N-1:0] id_instr,
  output logic [N-1:0] id_pc
`ifdef PHILV_FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_stall
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_nx;
  logic [N-1:0] pc, pc_nx;
  logic [CW-1:0] outst, outst_nx, cnt, cnt_nx;
  logic [AW-1:0] wp, rp;
  logic [N-1:0] q_instr [FIFO_DEPTH];
  logic [N-1:0] q_pc [FIFO_DEPTH];
  logic acc, dec, push, pop;
  // Credit-limited request issue, response filtering and next-state; in RUN the oldest outstanding request sits at pc - 4*outst
  always_comb begin
    imem_req = !rst && state == RUN && !redirect_valid && (outst + cnt < CW'(FIFO_DEPTH));
    imem_addr = rst ? START_ADDR : pc;
    acc = imem_req & imem_ready;
    dec = imem_rvalid && outst != '0;
    push = dec && state == RUN && !redirect_valid;
    id_valid = !rst && cnt != '0;
    id_instr = id_valid ? q_instr[rp] : '0;
    id_pc = id_valid ? q_pc[rp] : '0;
    pop = id_valid & id_ready;
    outst_nx = outst + CW'(acc) - CW'(dec);
    cnt_nx = redirect_valid ? '0 : cnt + CW'(push) - CW'(pop);
    pc_nx = redirect_valid ? (redirect_addr & ~N'(3)) : acc ? pc + N'(4) : pc;
    state_nx = outst_nx == '0 ? RUN : redirect_valid ? FLUSH : state;
  end
  // Control state: PC, outstanding/stale count, queue occupancy and pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc <= START_ADDR;
      outst <= '0;
      cnt <= '0;
      wp <= '0;
      rp <= '0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      outst <= outst_nx;
      cnt <= cnt_nx;
      wp <= redirect_valid ? '0 : wp + AW'(push);
      rp <= redirect_valid ? '0 : rp + AW'(pop);
    end
  end
  // Queue storage; the credit rule guarantees a free slot on every push
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wp] <= imem_rdata;
      q_pc[wp] <= pc - (N'(outst) << 2);
    end
  end
`ifdef PHILV_FETCH_PERF_EN
  // Pop count and decode-starved cycles, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      perf_stall <= perf_stall + 32'(id_ready & ~id_valid);
    end
  end
`endif
endmodule

// File: tb/tb_philv_fetch_unit.sv
// tb_philv_fetch_unit: randomized scoreboard bench for philv_fetch_unit
module tb_philv_fetch_unit;
  localparam int D = 2;
  localparam logic [31:0] START = 32'hFFFF_FFF8;
  logic clk = 0, rst = 1, imem_req, imem_ready = 0, imem_rvalid = 0;
  logic redirect_valid = 0, id_valid, id_ready = 0;
  logic [31:0] imem_addr, imem_rdata = '0, redirect_addr = '0, id_instr, id_pc;
`ifdef PHILV_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif
  int n_checks = 0, n_err = 0, cyc = 0, pops_since_rst = 0;
  logic [31:0] exp_q[$], mem_a[$];
  int mem_due[$];
  logic [31:0] next_exp = START;
  logic after_redir = 0, prev_rst = 1;
  int p_ready = 100, p_idr = 100, p_redir = 0, lat_min = 1, lat_max = 1;

  always #5 clk = ~clk;

  philv_fetch_unit #(.N(32), .START_ADDR(START), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
`ifdef PHILV_FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // expected decode stream: contiguous words from the last reset/redirect target
  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_exp);
      next_exp += 32'd4;
    end
  endtask

  // monitor: pops the scoreboard on every decode handshake
  initial begin
    logic hold = 0, pend = 0, was_rst = 1;
    logic [31:0] h_pc = '0, h_in = '0, p_addr = '0, e;
    int idle = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_valid", 32'(id_valid), 0);
        chk("rst_addr", imem_addr, START);
        chk("rst_instr", id_instr, 0);
        chk("rst_pc", id_pc, 0);
        hold = 0; pend = 0; idle = 0; pops_since_rst = 0; was_rst = 1;
      end else begin
        if (was_rst) begin
          chk("first_req", 32'(imem_req), 1);
          chk("first_addr", imem_addr, START);
        end
        was_rst = 0;
        if (after_redir) chk("redir_empty", 32'(id_valid), 0);
        if (hold) begin
          chk("hold_valid", 32'(id_valid), 1);
          chk("hold_pc", id_pc, h_pc);
          chk("hold_instr", id_instr, h_in);
        end
        if (pend && !redirect_valid) begin
          chk("pend_req", 32'(imem_req), 1);
          chk("pend_addr", imem_addr, p_addr);
        end
        if (imem_req) chk("addr_align", 32'(imem_addr[1:0]), 0);
        if (id_valid && id_ready) begin
          idle = 0;
          pops_since_rst++;
          if (exp_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL pop_unexpected: got pc %h expected no instruction", id_pc);
          end else begin
            e = exp_q.pop_front();
            chk("id_pc", id_pc, e);
            chk("id_instr", id_instr, word(e));
          end
        end else if (++idle > 200) begin
          n_checks++; n_err++;
          $display("FAIL watchdog: got no pop for 200 cycles, expected progress at cycle %0d", cyc);
          idle = 0;
        end
        hold = id_valid && !id_ready && !redirect_valid;
        pend = imem_req && !imem_ready;
        h_pc = id_pc; h_in = id_instr; p_addr = imem_addr;
      end
    end
  end

  // stimulus and memory model
  initial begin
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk); #1;
      cyc++;
      prev_rst = rst;
      rst = (c < 3) || (c >= 3000 && c < 3002);
      p_ready = 100; p_idr = 100; p_redir = 0; lat_min = 1; lat_max = 1;
      if (c >= 300 && c < 320) p_idr = 0;
      if (c >= 400 && c < 410) p_ready = 0;
      if (c >= 500 && c < 540) begin lat_min = 3; lat_max = 3; end
      if (c >= 600) begin p_ready = 70; p_idr = 70; p_redir = 5; lat_max = 4; end
      if (rst) begin
        exp_q.delete(); next_exp = START; refill();
        mem_a.delete(); mem_due.delete();
        after_redir = 0; imem_rvalid = 0; redirect_valid = 0;
      end else begin
        after_redir = redirect_valid;
        if (redirect_valid) begin
          exp_q.delete();
          next_exp = redirect_addr & ~32'd3;
        end
        refill();
        imem_rvalid = mem_a.size() > 0 && mem_due[0] <= cyc;
        imem_rdata = imem_rvalid ? word(mem_a[0]) : $urandom;
        imem_ready = $urandom_range(99) < p_ready;
        id_ready = $urandom_range(99) < p_idr;
        redirect_valid = !prev_rst && ($urandom_range(99) < p_redir || c == 405 || c == 515);
        case ($urandom_range(3))
          0: redirect_addr = 32'h104;
          1: redirect_addr = 32'hFFFF_FFF0 | 32'($urandom_range(15));
          2: redirect_addr = $urandom;
          default: redirect_addr = $urandom & 32'hFFF;
        endcase
        if (c == 405 || c == 515) redirect_addr = 32'h104;
      end
      @(negedge clk);
      if (!rst) begin
        if (imem_req && imem_ready) begin
          mem_a.push_back(imem_addr);
          mem_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
        end
        if (imem_rvalid) begin
          void'(mem_a.pop_front());
          void'(mem_due.pop_front());
        end
        chk("outstanding_cap", 32'(mem_a.size() <= D), 1);
        if (c == 319) begin
          chk("t2_req_off", 32'(imem_req), 0);
          chk("t2_full", 32'(id_valid), 1);
        end
        if (c == 406) begin
          chk("t5_req", 32'(imem_req), 1);
          chk("t5_addr", imem_addr, 32'h104);
        end
      end
    end
    @(posedge clk); #1;
    id_ready = 0; redirect_valid = 0;
    @(posedge clk); #1;
`ifdef PHILV_FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 32'(pops_since_rst));
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
